cr16_control_fsm: RTL and testbench

Multicycle control unit that drives the 16-bit ALU/register-file datapath. It fetches instruction words over a simple request/valid port, holds the current word in an instruction register, and decodes it into ALU control, register addresses, immediate and write strobes. It also evaluates conditional branches from the PSR flags that the datapath returns. It sits between instruction memory and the datapath and owns the program counter.

---
 rtl/cr16_control_fsm.sv | 127 ++++++++++++
 tb/tb_cr16_control_fsm.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr16_control_fsm.sv
// Multicycle control unit for the CR16-style 16-bit datapath: fetches over a
// request/valid port, decodes the instruction register and owns the PC.
module cr16_control_fsm #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned REGBITS = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [WIDTH-1:0]   pc,
    input  logic               imem_valid,
    input  logic [15:0]        imem_rdata,
    output logic [15:0]        instr,
    output logic [5:0]         alucont,
    output logic [REGBITS-1:0] ra1,
    output logic [REGBITS-1:0] ra2,
    output logic               use_imm,
    output logic [WIDTH-1:0]   imm,
    output logic               regwrite,
    output logic               psr_we,
    input  logic [WIDTH-1:0]   psr_flags,
    output logic               halted
);

    typedef enum logic [1:0] {StFetch, StDecode, StExec, StHalt} state_e;

    localparam logic [WIDTH-1:0] PcOne = 1;

    state_e             r_state, w_state_next;
    logic [WIDTH-1:0]   r_pc, w_pc_next;
    logic [15:0]        r_instr, w_instr_next;

    logic [3:0]         w_op, w_rd, w_ext, w_rs;
    logic [7:0]         w_imm8;
    logic               w_is_rr, w_is_imm, w_is_br, w_is_halt, w_is_alu, w_is_cmp;
    logic               w_cond_true, w_br_taken;
    logic [WIDTH-1:0]   w_disp;
    logic               w_flag_c, w_flag_l, w_flag_z, w_flag_n;
    logic               w_unused_flags;

    assign w_op   = r_instr[15:12];
    assign w_rd   = r_instr[11:8];
    assign w_ext  = r_instr[7:4];
    assign w_rs   = r_instr[3:0];
    assign w_imm8 = r_instr[7:0];

    assign w_is_rr   = (w_op == 4'h0);
    assign w_is_imm  = (w_op >= 4'h1) && (w_op <= 4'hB);
    assign w_is_br   = (w_op == 4'hC);
    assign w_is_halt = (r_instr == 16'hFFFF);
    assign w_is_alu  = w_is_rr || w_is_imm;
    assign w_is_cmp  = (w_is_rr && (w_ext == 4'hB)) || (w_op == 4'hB);

    assign w_flag_c = psr_flags[0];
    assign w_flag_l = psr_flags[2];
    assign w_flag_z = psr_flags[6];
    assign w_flag_n = psr_flags[7];
    assign w_unused_flags = ^{psr_flags[WIDTH-1:8], psr_flags[5:3], psr_flags[1]};

    assign w_disp = {{(WIDTH-8){w_imm8[7]}}, w_imm8};

    always_comb begin
        w_cond_true = 1'b0;
        case (w_rd)
            4'd0:    w_cond_true = w_flag_z;
            4'd1:    w_cond_true = !w_flag_z;
            4'd2:    w_cond_true = w_flag_c;
            4'd3:    w_cond_true = !w_flag_c;
            4'd4:    w_cond_true = w_flag_l;
            4'd5:    w_cond_true = !w_flag_l;
            4'd6:    w_cond_true = w_flag_n;
            4'd7:    w_cond_true = !w_flag_n;
            4'd14:   w_cond_true = 1'b1;
            default: w_cond_true = 1'b0;
        endcase
    end

    assign w_br_taken = w_is_br && w_cond_true;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_instr_next = r_instr;
        unique case (r_state)
            StFetch: begin
                if (imem_valid) begin
                    w_instr_next = imem_rdata;
                    w_state_next = StDecode;
                end
            end
            StDecode: w_state_next = StExec;
            StExec: begin
                w_pc_next    = w_br_taken ? (r_pc + w_disp) : (r_pc + PcOne);
                w_state_next = w_is_halt ? StHalt : StFetch;
            end
            StHalt: w_state_next = StHalt;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StFetch;
            r_pc    <= '0;
            r_instr <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_instr <= w_instr_next;
        end
    end

    // Gated by reset_n so no fetch is requested while reset is held.
    assign imem_req = reset_n && (r_state == StFetch);
    assign pc       = r_pc;
    assign instr    = r_instr;
    assign halted   = (r_state == StHalt);

    assign alucont  = w_is_rr ? {2'b00, w_ext} : (w_is_imm ? {2'b01, w_op} : 6'd0);
    assign use_imm  = w_is_imm;
    assign ra1      = {{(REGBITS-4){1'b0}}, w_rd};
    assign ra2      = {{(REGBITS-4){1'b0}}, w_rs};
    assign imm      = {{(WIDTH-8){1'b0}}, w_imm8};

    assign regwrite = (r_state == StExec) && w_is_alu && !w_is_cmp;
    assign psr_we   = (r_state == StExec) && w_is_alu;

endmodule

// File: tb/tb_cr16_control_fsm.sv
// Self-checking bench for cr16_control_fsm: directed scenarios plus random
// instruction streams checked against an instruction-level reference model.
module tb_cr16_control_fsm;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned REGBITS = 5;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               imem_req;
    logic [WIDTH-1:0]   pc;
    logic               imem_valid;
    logic [15:0]        imem_rdata;
    logic [15:0]        instr;
    logic [5:0]         alucont;
    logic [REGBITS-1:0] ra1, ra2;
    logic               use_imm;
    logic [WIDTH-1:0]   imm;
    logic               regwrite, psr_we;
    logic [WIDTH-1:0]   psr_flags;
    logic               halted;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] m_pc;

    cr16_control_fsm #(.WIDTH(WIDTH), .REGBITS(REGBITS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .imem_req   (imem_req),
        .pc         (pc),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .alucont    (alucont),
        .ra1        (ra1),
        .ra2        (ra2),
        .use_imm    (use_imm),
        .imm        (imm),
        .regwrite   (regwrite),
        .psr_we     (psr_we),
        .psr_flags  (psr_flags),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Architectural next-pc: branches use the flag table, everything else adds one.
    function automatic logic [15:0] ref_next_pc(input logic [15:0] p, input logic [15:0] w,
                                                 input logic [15:0] f);
        int flag_bit [8];
        int cond, d, t;
        bit taken;
        flag_bit = '{6, 6, 0, 0, 2, 2, 7, 7};
        taken = 0;
        if (w[15:12] == 4'hC) begin
            cond = int'(w[11:8]);
            if (cond == 14) taken = 1;
            else if (cond < 8) taken = (f[flag_bit[cond]] == ((cond % 2) == 0));
        end
        d = 1;
        if (taken) d = (int'(w[7:0]) >= 128) ? int'(w[7:0]) - 256 : int'(w[7:0]);
        t = (int'(p) + d) & 32'h0000_FFFF;
        return 16'(t);
    endfunction

    task automatic do_reset();
        reset_n    = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = '0;
        psr_flags  = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        m_pc = '0;
    endtask

    // Runs one instruction from FETCH (at a negedge) to the following FETCH/HALT.
    task automatic exec_instr(input logic [15:0] w, input int waits, input logic [15:0] flags);
        int          op, ext;
        bit          alu, cmp, hlt;
        logic [5:0]  exp_alu;
        logic [15:0] exp_pc;
        op  = int'(w[15:12]);
        ext = int'(w[7:4]);
        alu = (op <= 11);
        cmp = (op == 11) || (op == 0 && ext == 11);
        hlt = (w == 16'hFFFF);
        exp_alu = (op == 0) ? 6'(ext) : 6'(16 + op);
        for (int i = 0; i <= waits; i++) begin
            imem_valid = (i == waits);
            imem_rdata = (i == waits) ? w : 16'($urandom);
            n_tests++;
            if (imem_req !== 1'b1 || pc !== m_pc) begin
                n_fail++;
                $display("FAIL fetch_wait: req=%b pc=%h, expected req=1 pc=%h", imem_req, pc, m_pc);
            end
            @(negedge clk);
        end
        // DECODE: keep a junk valid word on the port, which must be ignored.
        imem_valid = 1'b1;
        imem_rdata = 16'($urandom);
        psr_flags  = flags;
        n_tests++;
        if (instr !== w) begin
            n_fail++;
            $display("FAIL decode_instr: instr=%h, expected %h", instr, w);
        end
        n_tests++;
        if ({ra1, ra2, imm} !== {5'(w[11:8]), 5'(w[3:0]), 16'(w[7:0])}) begin
            n_fail++;
            $display("FAIL decode_fields: ra1=%h ra2=%h imm=%h, expected %h %h %h",
                     ra1, ra2, imm, w[11:8], w[3:0], w[7:0]);
        end
        if (alu) begin
            n_tests++;
            if ({alucont, use_imm} !== {exp_alu, op != 0}) begin
                n_fail++;
                $display("FAIL decode_alu: alucont=%h use_imm=%b, expected %h %b",
                         alucont, use_imm, exp_alu, op != 0);
            end
        end
        n_tests++;
        if ({imem_req, regwrite, psr_we, halted} !== 4'b0000) begin
            n_fail++;
            $display("FAIL decode_strobes: req/rw/pw/halt=%b, expected 0000",
                     {imem_req, regwrite, psr_we, halted});
        end
        @(negedge clk);
        // EXEC
        n_tests++;
        if ({regwrite, psr_we, imem_req, instr} !== {alu && !cmp, alu, 1'b0, w}) begin
            n_fail++;
            $display("FAIL exec_strobes: rw=%b pw=%b req=%b instr=%h, expected %b %b 0 %h",
                     regwrite, psr_we, imem_req, instr, alu && !cmp, alu, w);
        end
        exp_pc = ref_next_pc(m_pc, w, flags);
        imem_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (pc !== exp_pc || halted !== hlt || imem_req !== !hlt) begin
            n_fail++;
            $display("FAIL next_pc: pc=%h halted=%b req=%b, expected %h %b %b (instr %h)",
                     pc, halted, imem_req, exp_pc, hlt, !hlt, w);
        end
        m_pc = exp_pc;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = 16'h1234;
        psr_flags  = '0;
        @(negedge clk);
        n_tests++;
        if ({imem_req, pc, instr, halted, regwrite, psr_we, alucont, ra1, ra2, use_imm} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: req=%b pc=%h instr=%h halted=%b rw=%b pw=%b alu=%h ra1=%h ra2=%h ui=%b, expected all 0",
                     imem_req, pc, instr, halted, regwrite, psr_we, alucont, ra1, ra2, use_imm);
        end
        imem_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (imem_req !== 1'b1 || pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_release: req=%b pc=%h, expected 1 0000", imem_req, pc);
        end
        m_pc = '0;
    endtask

    task automatic test_rr_add();
        do_reset();
        exec_instr(16'h0153, 0, 16'h0000);
        n_tests++;
        if (pc !== 16'h0001 || alucont !== 6'h05) begin
            n_fail++;
            $display("FAIL rr_add: pc=%h alucont=%h, expected 0001 05", pc, alucont);
        end
    endtask

    task automatic test_imm_wait();
        exec_instr(16'h52F0, 2, 16'h0000);
        n_tests++;
        if (alucont !== 6'h15 || imm !== 16'h00F0 || ra1 !== 5'd2 || use_imm !== 1'b1) begin
            n_fail++;
            $display("FAIL imm_wait: alucont=%h imm=%h ra1=%h use_imm=%b, expected 15 00f0 02 1",
                     alucont, imm, ra1, use_imm);
        end
    endtask

    task automatic test_cmp();
        exec_instr(16'hB405, 1, 16'h0000);
        exec_instr(16'h01B3, 0, 16'h0000);
    endtask

    task automatic test_branch();
        do_reset();
        repeat (16) exec_instr(16'hD000, 0, 16'h0000);
        exec_instr(16'hC0FC, 0, 16'h0040);
        n_tests++;
        if (pc !== 16'h000C) begin
            n_fail++;
            $display("FAIL branch_taken: pc=%h, expected 000c", pc);
        end
        repeat (4) exec_instr(16'hD000, 0, 16'h0000);
        exec_instr(16'hC0FC, 0, 16'h0000);
        n_tests++;
        if (pc !== 16'h0011) begin
            n_fail++;
            $display("FAIL branch_not_taken: pc=%h, expected 0011", pc);
        end
        exec_instr(16'hC905, 0, 16'hFFFF);
        n_tests++;
        if (pc !== 16'h0012) begin
            n_fail++;
            $display("FAIL branch_cond9: pc=%h, expected 0012", pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        exec_instr(16'hCEFF, 0, 16'h0000);
        n_tests++;
        if (pc !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_neg: pc=%h, expected ffff", pc);
        end
        exec_instr(16'hE000, 0, 16'h0000);
        n_tests++;
        if (pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_pos: pc=%h, expected 0000", pc);
        end
    endtask

    task automatic test_random();
        logic [15:0] w;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            w = 16'($urandom);
            if (w == 16'hFFFF) w = 16'h0000;
            exec_instr(w, int'($urandom_range(0, 3)), 16'($urandom));
        end
    endtask

    task automatic test_reset_mid_exec();
        do_reset();
        repeat (2) exec_instr(16'hD000, 0, 16'h0000);
        imem_valid = 1'b1;
        imem_rdata = 16'h0153;
        @(negedge clk);
        imem_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (regwrite !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_exec_pre: regwrite=%b, expected 1", regwrite);
        end
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (regwrite !== 1'b0 || psr_we !== 1'b0 || pc !== 16'h0000 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_exec_reset: rw=%b pw=%b pc=%h req=%b, expected 0 0 0000 0",
                     regwrite, psr_we, pc, imem_req);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (imem_req !== 1'b1 || pc !== 16'h0000 || regwrite !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_exec_release: req=%b pc=%h rw=%b, expected 1 0000 0",
                     imem_req, pc, regwrite);
        end
        m_pc = '0;
    endtask

    task automatic test_halt();
        do_reset();
        repeat (3) exec_instr(16'hD000, 0, 16'h0000);
        exec_instr(16'hFFFF, 1, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            imem_valid = 1'($urandom);
            imem_rdata = 16'($urandom);
            @(negedge clk);
            n_tests++;
            if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== m_pc || regwrite !== 1'b0 ||
                psr_we !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_hold[%0d]: halted=%b req=%b pc=%h rw=%b pw=%b, expected 1 0 %h 0 0",
                         i, halted, imem_req, pc, regwrite, psr_we, m_pc);
            end
        end
        imem_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (halted !== 1'b0 || pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL halt_reset: halted=%b pc=%h, expected 0 0000", halted, pc);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (imem_req !== 1'b1 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_release: req=%b halted=%b, expected 1 0", imem_req, halted);
        end
    endtask

    initial begin
        m_pc = '0;
        test_reset();
        test_rr_add();
        test_imm_wait();
        test_cmp();
        test_branch();
        test_wrap();
        test_random();
        test_reset_mid_exec();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
